// File: rtl/name_suite_req_arbiter.sv
// Round-robin arbiter that merges NREQ requestor channels into one memory
// request port through a DEPTH-entry FIFO tagged with the source id.
// Optional stall counter is enabled by defining NAME_SUITE_ARB_STATS_EN.
module name_suite_req_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 2,
  localparam int SW   = $clog2(NREQ),
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_bits,
  output logic               mem_valid,
  input  logic               mem_ready,
  output logic [DW-1:0]      mem_bits,
  output logic [SW-1:0]      mem_src,
  output logic [CW-1:0]      fifo_count
`ifdef NAME_SUITE_ARB_STATS_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  logic [DW-1:0] data_q [DEPTH];
  logic [SW-1:0] src_q  [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] last_ptr;

  logic          grant_found;
  logic [SW-1:0] grant_idx;
  logic [SW-1:0] scan_idx;
  logic          has_room;
  logic          push;
  logic          pop;

  // Scan starts one past the last winner so every requestor gets its turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int off = 1; off <= NREQ; off++) begin
      scan_idx = last_ptr + SW'(off);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Room is judged on current occupancy only, keeping mem_ready off the grant path.
  assign has_room  = (count < CW'(DEPTH));
  assign push      = grant_found && has_room;
  assign pop       = (count != '0) && mem_ready;
  assign req_ready = push ? (NREQ'(1) << grant_idx) : '0;

  assign mem_valid  = (count != '0);
  assign mem_bits   = data_q[rd_ptr];
  assign mem_src    = src_q[rd_ptr];
  assign fifo_count = count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        src_q[i]  <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_ptr <= SW'(NREQ - 1);
    end else begin
      if (push) begin
        data_q[wr_ptr] <= req_bits[grant_idx*DW +: DW];
        src_q[wr_ptr]  <= grant_idx;
        wr_ptr         <= wr_ptr + PW'(1);
        last_ptr       <= grant_idx;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifdef NAME_SUITE_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (|req_valid && !has_room && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_name_suite_req_arbiter.sv
// Scoreboard bench for name_suite_req_arbiter: a reference model predicts
// grants and queues expected {src,bits} entries that are checked at the head.
module tb_name_suite_req_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 2;

  logic              clk;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*DW-1:0] req_bits;
  logic              mem_valid;
  logic              mem_ready;
  logic [DW-1:0]     mem_bits;
  logic [1:0]        mem_src;
  logic [1:0]        fifo_count;
`ifdef NAME_SUITE_ARB_STATS_EN
  logic [15:0]       stall_cnt;
`endif

  name_suite_req_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_bits   (req_bits),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_bits   (mem_bits),
    .mem_src    (mem_src),
    .fifo_count (fifo_count)
`ifdef NAME_SUITE_ARB_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         compared;
  int         mismatched;
  logic [9:0] sb [$];
  int         m_count;
  int         m_ptr;
  int         m_stall;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int modelGrant(input logic [3:0] v, input int ptr);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // One cycle: drive after the edge, check against the model, then advance the model.
  task automatic applyStimulus(input logic [3:0] valid, input logic rdy, input logic rand_bits);
    int         g;
    logic [3:0] exp_ready;
    logic       pop;
    @(posedge clk);
    #1;
    req_valid = valid;
    mem_ready = rdy;
    req_bits  = rand_bits ? 32'($urandom) : 32'hA3A2A1A0;
    #1;
    checkOutput("fifo_count", 32'(fifo_count), 32'(m_count));
    checkOutput("mem_valid", 32'(mem_valid), 32'(m_count != 0));
    if (m_count != 0) begin
      checkOutput("mem_bits", 32'(mem_bits), 32'(sb[0][7:0]));
      checkOutput("mem_src", 32'(mem_src), 32'(sb[0][9:8]));
    end
`ifdef NAME_SUITE_ARB_STATS_EN
    checkOutput("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    g = (m_count < DEPTH) ? modelGrant(valid, m_ptr) : -1;
    exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    pop = (m_count != 0) && rdy;
    if (pop) void'(sb.pop_front());
    if (g >= 0) begin
      sb.push_back({2'(g), req_bits[g*DW +: DW]});
      m_ptr = g;
    end
    if (|valid && m_count == DEPTH && m_stall != 16'hFFFF) m_stall++;
    m_count = m_count + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
  endtask

  task automatic applyReset();
    @(posedge clk);
    #3;
    req_valid = '0;
    reset_n   = 1'b0;
    #1;
    checkOutput("rst_mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    sb.delete();
    m_count = 0;
    m_ptr   = NREQ - 1;
    m_stall = 0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    m_count    = 0;
    m_ptr      = NREQ - 1;
    m_stall    = 0;
    reset_n    = 1'b0;
    req_valid  = '0;
    req_bits   = '0;
    mem_ready  = 1'b0;
    #12;
    $display("[TB] checking reset state");
    checkOutput("init_mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("init_mem_bits", 32'(mem_bits), 32'd0);
    checkOutput("init_mem_src", 32'(mem_src), 32'd0);
    checkOutput("init_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("init_req_ready", 32'(req_ready), 32'd0);
    #3;
    reset_n = 1'b1;

    $display("[TB] all requestors valid, streaming");
    for (int i = 0; i < 10; i++) applyStimulus(4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(4'h0, 1'b1, 1'b0);

    $display("[TB] single requestor then rotation to req 3");
    for (int i = 0; i < 5; i++) applyStimulus(4'b0100, 1'b1, 1'b1);
    applyStimulus(4'b1100, 1'b1, 1'b1);
    applyStimulus(4'b1100, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(4'h0, 1'b1, 1'b1);

    $display("[TB] back-pressure fills the fifo");
    applyReset();
    for (int i = 0; i < 6; i++) applyStimulus(4'hF, 1'b0, 1'b1);
    applyStimulus(4'hF, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(4'hF, 1'b0, 1'b1);

    $display("[TB] async reset with entries queued");
    applyReset();
    for (int i = 0; i < 4; i++) applyStimulus(4'hF, 1'b1, 1'b1);

    $display("[TB] random traffic wrapping pointers");
    for (int i = 0; i < 80; i++) begin
      applyStimulus(4'($urandom), 1'($urandom_range(0, 3) != 0), 1'b1);
    end
    for (int i = 0; i < 4; i++) applyStimulus(4'h0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
